// File: rtl/sd_sector_seq_if.sv
// sd_sector_seq_if: command, status, SD byte stream and buffer port B bundle for sd_sector_seq.
// master = sequencer side (drives status, tx stream, buffer port B); slave = CPU/SD/RAM side.
// With SD_SECTOR_SEQ_PINGPONG_EN defined, buf_addr gains a bank MSB (ADDRWIDTH+1 bits).
interface sd_sector_seq_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9
);
`ifdef SD_SECTOR_SEQ_PINGPONG_EN
    localparam int BUFAW = ADDRWIDTH + 1;
`else
    localparam int BUFAW = ADDRWIDTH;
`endif

    logic                 cmd_fill;
    logic                 cmd_drain;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [DATAWIDTH-1:0] rx_data;
    logic                 rx_valid;
    logic [DATAWIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [BUFAW-1:0]     buf_addr;
    logic [DATAWIDTH-1:0] buf_wdata;
    logic                 buf_wren;
    logic [DATAWIDTH-1:0] buf_rdata;
    logic                 cpu_bank;

    modport master (
        input  cmd_fill, cmd_drain, abort, rx_data, rx_valid, tx_ready, buf_rdata,
        output busy, done, tx_data, tx_valid, buf_addr, buf_wdata, buf_wren, cpu_bank
    );

    modport slave (
        output cmd_fill, cmd_drain, abort, rx_data, rx_valid, tx_ready, buf_rdata,
        input  busy, done, tx_data, tx_valid, buf_addr, buf_wdata, buf_wren, cpu_bank
    );
endinterface

// File: rtl/sd_sector_seq.sv
// sd_sector_seq: moves one sector per command between the SD byte stream and buffer RAM port B.
// Latency: busy 1 cycle after command; fill writes 1 cycle after rx_valid (1 B/cycle); drain 3 cycles/byte.
// Backpressure: none on rx (every rx_valid byte is written); tx holds tx_data/tx_valid until tx_ready.
// Ports: clock, reset (async, active-high), seq_if (master modport of sd_sector_seq_if).
// Optional ping-pong banks: define SD_SECTOR_SEQ_PINGPONG_EN (buf_addr MSB = bank, cpu_bank = ~bank).
module sd_sector_seq #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9
) (
    input  logic            clock,
    input  logic            reset,
    sd_sector_seq_if.master seq_if
);
`ifdef SD_SECTOR_SEQ_PINGPONG_EN
    localparam int BUFAW = ADDRWIDTH + 1;
`else
    localparam int BUFAW = ADDRWIDTH;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_RDREQ, S_RDWAIT, S_TXHOLD, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRWIDTH-1:0] ptr_inc;
    logic [BUFAW-1:0]     buf_addr_q, buf_addr_d;
    logic [DATAWIDTH-1:0] buf_wdata_q, buf_wdata_d;
    logic                 buf_wren_q, buf_wren_d;
    logic [DATAWIDTH-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [BUFAW-1:0]     addr_zero, addr_cur, addr_nxt;
    logic                 ptr_last;

    assign ptr_inc  = ptr_q + 1'b1;
    assign ptr_last = &ptr_q;

`ifdef SD_SECTOR_SEQ_PINGPONG_EN
    logic bank_q, bank_d;
    assign addr_zero = {bank_q, {ADDRWIDTH{1'b0}}};
    assign addr_cur  = {bank_q, ptr_q};
    assign addr_nxt  = {bank_q, ptr_inc};
    assign seq_if.cpu_bank = ~bank_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) bank_q <= 1'b0;
        else       bank_q <= bank_d;
    end

    always_comb begin
        bank_d = bank_q;
        if (state_q == S_DONE && !seq_if.abort) bank_d = ~bank_q;
    end
`else
    assign addr_zero = '0;
    assign addr_cur  = ptr_q;
    assign addr_nxt  = ptr_inc;
    assign seq_if.cpu_bank = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_wren_d  = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        case (state_q)
            S_IDLE: begin
                // Fill has priority when both commands arrive together.
                if (seq_if.cmd_fill) begin
                    state_d = S_FILL;
                    ptr_d   = '0;
                end else if (seq_if.cmd_drain) begin
                    state_d    = S_RDREQ;
                    ptr_d      = '0;
                    buf_addr_d = addr_zero;
                end
            end
            S_FILL: begin
                if (seq_if.rx_valid) begin
                    buf_addr_d  = addr_cur;
                    buf_wdata_d = seq_if.rx_data;
                    buf_wren_d  = 1'b1;
                    if (ptr_last) state_d = S_DONE;
                    else          ptr_d   = ptr_inc;
                end
            end
            // The read address is already registered on entry to RDREQ, so the
            // RAM returns the byte during RDWAIT.
            S_RDREQ:  state_d = S_RDWAIT;
            S_RDWAIT: begin
                tx_data_d  = seq_if.buf_rdata;
                tx_valid_d = 1'b1;
                state_d    = S_TXHOLD;
            end
            S_TXHOLD: begin
                if (seq_if.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (ptr_last) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d      = ptr_inc;
                        buf_addr_d = addr_nxt;
                        state_d    = S_RDREQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a command arriving in IDLE.
        if (seq_if.abort) begin
            state_d    = S_IDLE;
            ptr_d      = ptr_q;
            buf_addr_d = buf_addr_q;
            buf_wren_d = 1'b0;
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_wren_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_wren_q  <= buf_wren_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign seq_if.busy      = (state_q != S_IDLE);
    assign seq_if.done      = (state_q == S_DONE) && !seq_if.abort;
    assign seq_if.buf_addr  = buf_addr_q;
    assign seq_if.buf_wdata = buf_wdata_q;
    assign seq_if.buf_wren  = buf_wren_q;
    assign seq_if.tx_data   = tx_data_q;
    assign seq_if.tx_valid  = tx_valid_q;
endmodule

// File: tb/tb_sd_sector_seq.sv
module tb_sd_sector_seq;
    localparam int AW = 9;
`ifdef SD_SECTOR_SEQ_PINGPONG_EN
    localparam int BAW = AW + 1;
    localparam bit PP  = 1'b1;
`else
    localparam int BAW = AW;
    localparam bit PP  = 1'b0;
`endif

    typedef struct {
        logic [BAW-1:0] addr;
        logic [7:0]     data;
    } wr_t;

    typedef struct {
        bit fill, drain, abrt, exp_busy, exp_txv;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sd_sector_seq_if #(.DATAWIDTH(8), .ADDRWIDTH(AW)) sif();
    sd_sector_seq #(.DATAWIDTH(8), .ADDRWIDTH(AW)) dut (
        .clock  (clock),
        .reset  (reset),
        .seq_if (sif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   txv_cycles = 0;
    int   tx_acc_cnt = 0;
    bit   exp_bank = 1'b0;
    bit   preload  = 1'b0;
    wr_t  exp_wr[$];
    logic [7:0] exp_tx[$];

    // Buffer RAM model, port B: synchronous read, one-cycle latency.
    logic [7:0] mem [0:(1<<BAW)-1];
    always @(posedge clock) begin
        if (preload) begin
            for (int a = 0; a < (1 << BAW); a++) mem[a] <= ~a[7:0];
        end else if (sif.buf_wren) begin
            mem[sif.buf_addr] <= sif.buf_wdata;
        end
        sif.buf_rdata <= mem[sif.buf_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BAW-1:0] exp_addr(input int i);
        logic [BAW-1:0] a;
        a = '0;
        a[AW-1:0] = i[AW-1:0];
        if (PP) a[BAW-1] = exp_bank;
        return a;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    wr_t        w;
    logic [7:0] t;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clock) begin
        if (sif.done) done_cnt++;
        if (sif.tx_valid) txv_cycles++;
        if (sif.buf_wren) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", sif.buf_addr, sif.buf_wdata);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(sif.buf_addr), 32'(w.addr));
                chk("wr_data", 32'(sif.buf_wdata), 32'(w.data));
            end
        end
        if (sif.tx_valid && sif.tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected: got byte %0h, expected none", sif.tx_data);
            end else begin
                t = exp_tx.pop_front();
                chk("tx_data", 32'(sif.tx_data), 32'(t));
            end
            tx_acc_cnt++;
        end
        if (prev_v && !prev_r && sif.tx_valid) chk("tx_stall_stable", 32'(sif.tx_data), 32'(prev_d));
        prev_v = sif.tx_valid;
        prev_r = sif.tx_ready;
        prev_d = sif.tx_data;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fill(input bit gap, input bit both, input int drain_at, input int reset_at);
        int d0, t0, busy_low;
        d0 = done_cnt; t0 = txv_cycles; busy_low = 0;
        sif.cmd_fill  = 1'b1;
        sif.cmd_drain = both;
        step();
        sif.cmd_fill  = 1'b0;
        sif.cmd_drain = 1'b0;
        if (!sif.busy) busy_low++;
        for (int i = 0; i < 512; i++) begin
            if (gap && i > 0 && (i % 2 == 0)) begin
                sif.rx_valid = 1'b0;
                step();
                if (!sif.busy) busy_low++;
            end
            if (i == reset_at) begin
                sif.rx_valid = 1'b0;
                reset = 1'b1;
                #1;
                chk("rst_mid_busy",     32'(sif.busy), 0);
                chk("rst_mid_wren",     32'(sif.buf_wren), 0);
                chk("rst_mid_addr",     32'(sif.buf_addr), 0);
                chk("rst_mid_wdata",    32'(sif.buf_wdata), 0);
                chk("rst_mid_done",     32'(sif.done), 0);
                chk("rst_mid_txv",      32'(sif.tx_valid), 0);
                chk("rst_mid_cpu_bank", 32'(sif.cpu_bank), PP ? 1 : 0);
                exp_wr.delete();
                exp_bank = 1'b0;
                step();
                reset = 1'b0;
                step();
                return;
            end
            sif.rx_valid  = 1'b1;
            sif.rx_data   = i[7:0];
            sif.cmd_drain = (i == drain_at);
            exp_wr.push_back('{exp_addr(i), i[7:0]});
            step();
            sif.cmd_drain = 1'b0;
            if (!sif.busy) busy_low++;
        end
        sif.rx_valid = 1'b0;
        for (int k = 0; k < 8 && done_cnt == d0; k++) step();
        chk("fill_done_count", 32'(done_cnt - d0), 1);
        chk("fill_busy_low_cycles", 32'(busy_low), 0);
        chk("fill_busy_after", 32'(sif.busy), 0);
        chk("fill_wr_left", 32'(exp_wr.size()), 0);
        if (PP) exp_bank = ~exp_bank;
        chk("fill_cpu_bank", 32'(sif.cpu_bank), PP ? 32'(~exp_bank) : 0);
        sif.tx_ready = 1'b1;
        repeat (10) step();
        sif.tx_ready = 1'b0;
        chk("fill_no_tx_after", 32'(txv_cycles - t0), 0);
    endtask

    task automatic do_drain(input int abort_at);
        int d0;
        bit aborted;
        preload = 1'b1;
        step();
        preload = 1'b0;
        exp_tx.delete();
        for (int j = 0; j < 512; j++) exp_tx.push_back(~j[7:0]);
        d0 = done_cnt; tx_acc_cnt = 0; aborted = 1'b0;
        sif.tx_ready  = 1'b0;
        sif.cmd_drain = 1'b1;
        step();
        sif.cmd_drain = 1'b0;
        chk("drain_busy_rise", 32'(sif.busy), 1);
        step();
        chk("drain_txv_early", 32'(sif.tx_valid), 0);
        step();
        chk("drain_txv_3cyc", 32'(sif.tx_valid), 1);
        for (int c = 0; c < 20000 && done_cnt == d0; c++) begin
            if (abort_at >= 0 && tx_acc_cnt == abort_at) begin
                sif.tx_ready = 1'b0;
                if (sif.tx_valid) begin
                    sif.abort = 1'b1;
                    step();
                    sif.abort = 1'b0;
                    chk("abort_txv", 32'(sif.tx_valid), 0);
                    chk("abort_busy", 32'(sif.busy), 0);
                    chk("abort_no_done", 32'(done_cnt - d0), 0);
                    aborted = 1'b1;
                    break;
                end
            end else begin
                sif.tx_ready = 1'($urandom_range(0, 1));
            end
            step();
        end
        sif.tx_ready = 1'b0;
        if (aborted) begin
            exp_tx.delete();
            repeat (3) step();
            chk("abort_still_no_done", 32'(done_cnt - d0), 0);
        end else begin
            chk("drain_done_count", 32'(done_cnt - d0), 1);
            chk("drain_bytes", 32'(tx_acc_cnt), 512);
            chk("drain_tx_left", 32'(exp_tx.size()), 0);
            chk("drain_busy_after", 32'(sif.busy), 0);
            if (PP) exp_bank = ~exp_bank;
            chk("drain_cpu_bank", 32'(sif.cpu_bank), PP ? 32'(~exp_bank) : 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   d0;
        vecs[0] = '{fill: 0, drain: 0, abrt: 0, exp_busy: 0, exp_txv: 0};
        vecs[1] = '{fill: 1, drain: 0, abrt: 0, exp_busy: 1, exp_txv: 0};
        vecs[2] = '{fill: 0, drain: 1, abrt: 0, exp_busy: 1, exp_txv: 1};
        vecs[3] = '{fill: 1, drain: 1, abrt: 0, exp_busy: 1, exp_txv: 0};
        vecs[4] = '{fill: 0, drain: 0, abrt: 1, exp_busy: 0, exp_txv: 0};
        vecs[5] = '{fill: 1, drain: 1, abrt: 1, exp_busy: 0, exp_txv: 0};

        sif.cmd_fill = 1'b0; sif.cmd_drain = 1'b0; sif.abort = 1'b0;
        sif.rx_data = 8'h00; sif.rx_valid = 1'b0; sif.tx_ready = 1'b0;
        #3;
        chk("rst_busy",     32'(sif.busy), 0);
        chk("rst_done",     32'(sif.done), 0);
        chk("rst_wren",     32'(sif.buf_wren), 0);
        chk("rst_txv",      32'(sif.tx_valid), 0);
        chk("rst_tx_data",  32'(sif.tx_data), 0);
        chk("rst_addr",     32'(sif.buf_addr), 0);
        chk("rst_wdata",    32'(sif.buf_wdata), 0);
        chk("rst_cpu_bank", 32'(sif.cpu_bank), PP ? 1 : 0);
        step();
        reset = 1'b0;
        step();

        // Command decode from IDLE, each vector cleaned up with an abort.
        d0 = done_cnt;
        for (int v = 0; v < 6; v++) begin
            sif.cmd_fill  = vecs[v].fill;
            sif.cmd_drain = vecs[v].drain;
            sif.abort     = vecs[v].abrt;
            step();
            sif.cmd_fill = 1'b0; sif.cmd_drain = 1'b0; sif.abort = 1'b0;
            chk($sformatf("vec%0d_busy", v), 32'(sif.busy), 32'(vecs[v].exp_busy));
            step();
            step();
            chk($sformatf("vec%0d_txv", v), 32'(sif.tx_valid), 32'(vecs[v].exp_txv));
            sif.abort = 1'b1;
            step();
            sif.abort = 1'b0;
            chk($sformatf("vec%0d_idle", v), 32'(sif.busy), 0);
            chk($sformatf("vec%0d_txv_off", v), 32'(sif.tx_valid), 0);
        end
        chk("vec_no_done", 32'(done_cnt - d0), 0);

        do_fill(1'b1, 1'b0, -1, -1);       // gapped fill
        do_drain(-1);                      // random backpressure drain
        do_drain(300);                     // abort mid-drain
        do_drain(-1);                      // restart from address 0
        do_fill(1'b0, 1'b1, 50, -1);       // fill+drain together, drain during fill
        do_fill(1'b0, 1'b0, -1, 100);      // reset after 100 bytes
        do_fill(1'b0, 1'b0, -1, -1);       // normal fill after reset
        do_fill(1'b1, 1'b0, -1, -1);       // second fill: other bank with ping-pong

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end
endmodule
